// File: rtl/x3_dec_accum.sv
// Digit-serial decimal-to-binary accumulator. Takes one decoded digit per
// handshake, MSD first, and presents the binary value of the frame together
// with error flags and a digit count on a valid/ready output port.
module x3_dec_accum #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned OUT_W = 14
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         digit_valid_i,
  input  logic [3:0]                   digit_i,
  input  logic                         digit_invalid_i,
  input  logic                         digit_last_i,
  output logic                         digit_ready_o,
  output logic                         result_valid_o,
  output logic [OUT_W-1:0]             result_o,
  output logic [1:0]                   result_err_o,
  output logic [$clog2(NDIG+1)-1:0]    result_ndig_o,
  input  logic                         result_ready_i
);

  localparam int unsigned CntW = $clog2(NDIG + 1);

  typedef enum logic {
    StAcc,
    StDone
  } state_e;

  state_e            state_q;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;

  logic              result_valid_q;
  logic [OUT_W-1:0]  result_q;
  logic [1:0]        result_err_q;
  logic [CntW-1:0]   result_ndig_q;

  logic              accept;
  logic              full;
  logic              bad_digit;
  logic [OUT_W-1:0]  digit_val;

  // Ready depends only on the state register and reset, never on the inputs.
  always_comb begin
    digit_ready_o = (state_q == StAcc) && !rst_i;
  end

  // Next accumulator contents if the presented digit is accepted this cycle.
  always_comb begin
    accept    = digit_valid_i && digit_ready_o;
    full      = (cnt_q == CntW'(NDIG));
    // Codes 10-15 cannot be a decimal digit, so they are handled like a flagged digit.
    bad_digit = digit_invalid_i || (digit_i > 4'd9);
    digit_val = bad_digit ? '0 : OUT_W'(digit_i);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (full) begin
      // Extra digits are swallowed; only the overflow flag records them.
      err_d[1] = 1'b1;
    end else begin
      // A bad digit still occupies its decimal position as a zero.
      acc_d    = (acc_q << 3) + (acc_q << 1) + digit_val;
      cnt_d    = cnt_q + CntW'(1);
      err_d[0] = err_q[0] | bad_digit;
    end
  end

  // Frame FSM: accumulate digits in StAcc, hold a registered result in StDone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StAcc;
      acc_q          <= '0;
      cnt_q          <= '0;
      err_q          <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_err_q   <= '0;
      result_ndig_q  <= '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (digit_last_i) begin
              state_q        <= StDone;
              result_valid_q <= 1'b1;
              result_q       <= acc_d;
              result_err_q   <= err_d;
              result_ndig_q  <= cnt_d;
            end
          end
        end
        StDone: begin
          if (result_ready_i) begin
            state_q        <= StAcc;
            acc_q          <= '0;
            cnt_q          <= '0;
            err_q          <= '0;
            result_valid_q <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign result_err_o   = result_err_q;
  assign result_ndig_o  = result_ndig_q;

endmodule

// File: tb/tb_x3_dec_accum.sv
// Self-checking bench for x3_dec_accum: directed scenarios plus random frames
// compared against a decimal-arithmetic reference model.
module tb_x3_dec_accum;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned OUT_W = 14;
  localparam int unsigned CW    = $clog2(NDIG + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             digit_valid = 1'b0;
  logic [3:0]       digit = 4'd0;
  logic             digit_invalid = 1'b0;
  logic             digit_last = 1'b0;
  logic             digit_ready;
  logic             result_valid;
  logic [OUT_W-1:0] result;
  logic [1:0]       result_err;
  logic [CW-1:0]    result_ndig;
  logic             result_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0] fr_d [16];
  logic       fr_i [16];

  always #5 clk = ~clk;

  x3_dec_accum #(
    .NDIG (NDIG),
    .OUT_W(OUT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .digit_valid_i  (digit_valid),
    .digit_i        (digit),
    .digit_invalid_i(digit_invalid),
    .digit_last_i   (digit_last),
    .digit_ready_o  (digit_ready),
    .result_valid_o (result_valid),
    .result_o       (result),
    .result_err_o   (result_err),
    .result_ndig_o  (result_ndig),
    .result_ready_i (result_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the first NDIG digits, bad digits count as 0.
  function automatic void model(input int n, output int v, output logic [1:0] e,
                                output int nd);
    v  = 0;
    e  = 2'b00;
    nd = (n > int'(NDIG)) ? int'(NDIG) : n;
    for (int i = 0; i < nd; i++) begin
      if (fr_i[i] || fr_d[i] > 4'd9) begin
        v    = v * 10;
        e[0] = 1'b1;
      end else begin
        v = v * 10 + int'(fr_d[i]);
      end
    end
    e[1] = (n > int'(NDIG));
  endfunction

  // Present one digit; the block must be ready, so it is accepted at the next edge.
  task automatic drive_digit(input logic [3:0] dv, input logic inv, input logic last,
                             input string tag);
    digit_valid   = 1'b1;
    digit         = dv;
    digit_invalid = inv;
    digit_last    = last;
    checks++;
    if (digit_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: ready=%b valid=%b, want ready=1 valid=0", tag, digit_ready,
               result_valid);
    end
    tick();
    digit_valid   = 1'b0;
    digit_invalid = 1'b0;
    digit_last    = 1'b0;
  endtask

  // Send fr_d/fr_i[0..n-1], check the result, stall for hold cycles, then consume.
  task automatic run_frame(input int n, input int hold, input bit bub, input string tag);
    int         v;
    int         nd;
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      if (bub && $urandom_range(0, 3) == 0) tick();
      drive_digit(fr_d[i], fr_i[i], (i == n - 1), tag);
    end
    model(n, v, e, nd);
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: result_valid=%b want 1", tag, result_valid);
    end
    checks++;
    if (result !== OUT_W'(v) || result_err !== e || result_ndig !== CW'(nd)) begin
      errors++;
      $display("FAIL %s result: got %0d err=%b ndig=%0d, want %0d err=%b ndig=%0d", tag,
               result, result_err, result_ndig, v, e, nd);
    end
    for (int h = 0; h < hold; h++) begin
      digit_valid = 1'b1;
      digit       = 4'($urandom_range(0, 15));
      digit_last  = 1'b1;
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== OUT_W'(v) || result_err !== e ||
          result_ndig !== CW'(nd) || digit_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: valid=%b res=%0d err=%b ndig=%0d ready=%b, want 1 %0d %b %0d 0",
                 tag, result_valid, result, result_err, result_ndig, digit_ready, v, e, nd);
      end
    end
    digit_valid  = 1'b0;
    digit_last   = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s consume: valid=%b ready=%b, want 0 1", tag, result_valid, digit_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (digit_ready !== 1'b0 || result_valid !== 1'b0 || result !== '0 ||
        result_err !== 2'b00 || result_ndig !== '0) begin
      errors++;
      $display("FAIL %s reset: ready=%b valid=%b res=%0d err=%b ndig=%0d, want all 0", tag,
               digit_ready, result_valid, result, result_err, result_ndig);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    checks++;
    if (digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready: got %b want 1", digit_ready);
    end
  endtask

  task automatic test_four_digits;
    for (int i = 0; i < 4; i++) begin
      fr_d[i] = 4'(i + 1);
      fr_i[i] = 1'b0;
    end
    run_frame(4, 0, 1'b0, "four");
  endtask

  task automatic test_single;
    fr_d[0] = 4'd7; fr_i[0] = 1'b0;
    run_frame(1, 0, 1'b0, "single");
    fr_d[0] = 4'd0; fr_d[1] = 4'd0; fr_d[2] = 4'd5;
    fr_i[0] = 1'b0; fr_i[1] = 1'b0; fr_i[2] = 1'b0;
    run_frame(3, 0, 1'b0, "zeros");
  endtask

  task automatic test_invalid;
    fr_d[0] = 4'd5; fr_d[1] = 4'hx; fr_d[2] = 4'd9;
    fr_i[0] = 1'b0; fr_i[1] = 1'b1; fr_i[2] = 1'b0;
    run_frame(3, 2, 1'b0, "invalid");
    fr_d[0] = 4'd1; fr_d[1] = 4'hC; fr_d[2] = 4'd2;
    fr_i[0] = 1'b0; fr_i[1] = 1'b0; fr_i[2] = 1'b0;
    run_frame(3, 0, 1'b0, "raw_c");
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      fr_d[i] = 4'd9;
      fr_i[i] = 1'b0;
    end
    run_frame(5, 0, 1'b0, "overflow");
  endtask

  task automatic test_backpressure;
    drive_digit(4'd4, 1'b0, 1'b0, "bp");
    drive_digit(4'd2, 1'b0, 1'b1, "bp");
    digit_valid = 1'b1;
    digit       = 4'd3;
    digit_last  = 1'b1;
    for (int h = 0; h < 6; h++) begin
      checks++;
      if (result_valid !== 1'b1 || result !== OUT_W'(42) || digit_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold: valid=%b res=%0d ready=%b, want 1 42 0", result_valid, result,
                 digit_ready);
      end
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp release: valid=%b ready=%b, want 0 1", result_valid, digit_ready);
    end
    tick();
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== OUT_W'(3) || result_ndig !== CW'(1) ||
        result_err !== 2'b00) begin
      errors++;
      $display("FAIL bp next: valid=%b res=%0d ndig=%0d err=%b, want 1 3 1 00", result_valid,
               result, result_ndig, result_err);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive_digit(4'd8, 1'b0, 1'b0, "rst_mid");
    drive_digit(4'd8, 1'b0, 1'b0, "rst_mid");
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    #1;
    fr_d[0] = 4'd6; fr_i[0] = 1'b0;
    run_frame(1, 0, 1'b0, "after_rst");
    drive_digit(4'd3, 1'b0, 1'b1, "rst_done");
    rst = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_done valid: got %b want 0", result_valid);
    end
    rst = 1'b0;
    #1;
    fr_d[0] = 4'd2; fr_i[0] = 1'b0;
    run_frame(1, 0, 1'b0, "after_rst_done");
  endtask

  task automatic test_random;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) begin
        fr_d[i] = 4'($urandom_range(0, 15));
        if (fr_d[i] > 4'd9 && $urandom_range(0, 1) == 0) fr_d[i] = 4'($urandom_range(0, 9));
        fr_i[i] = ($urandom_range(0, 5) == 0);
      end
      run_frame(n, int'($urandom_range(0, 3)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_four_digits();
    test_single();
    test_invalid();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
